// File: rtl/ace_snoop_pkg.sv
// ace_snoop_pkg: shared definitions for the ACE snoop initiator.
//   - ACSNOOP encodings driven on acsnoop
//   - CRRESP bit positions decoded from crresp
//   - initiator FSM state enum
//   - saturating beat counter helper
package ace_snoop_pkg;

    // ACSNOOP encodings
    localparam logic [3:0] SNP_READ_ONCE        = 4'b0000;
    localparam logic [3:0] SNP_READ_SHARED      = 4'b0001;
    localparam logic [3:0] SNP_READ_CLEAN       = 4'b0010;
    localparam logic [3:0] SNP_READ_NSD         = 4'b0011;
    localparam logic [3:0] SNP_READ_UNIQUE      = 4'b0111;
    localparam logic [3:0] SNP_CLEAN_SHARED     = 4'b1000;
    localparam logic [3:0] SNP_CLEAN_INVALID    = 4'b1001;
    localparam logic [3:0] SNP_MAKE_INVALID     = 4'b1101;
    localparam logic [3:0] SNP_DVM_COMPLETE     = 4'b1110;
    localparam logic [3:0] SNP_DVM_MESSAGE      = 4'b1111;

    // CRRESP bit positions
    localparam int CR_DATA_TRANSFER = 0;
    localparam int CR_ERROR         = 1;
    localparam int CR_PASS_DIRTY    = 2;
    localparam int CR_IS_SHARED     = 3;
    localparam int CR_WAS_UNIQUE    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AC,
        ST_CR,
        ST_CD,
        ST_DONE
    } snoop_state_e;

    // Beat count sticks at 15 rather than wrapping.
    function automatic logic [3:0] beat_inc(input logic [3:0] b);
        return (b == 4'hF) ? b : b + 4'd1;
    endfunction

endpackage

// File: rtl/ace_snoop_initiator_if.sv
// ace_snoop_initiator_if: command, AC, CR, CD and result channels of the
// snoop initiator bundled in one interface.
//   Parameters: ADDR_W (AC address), CD_W (CD data), LAT_W (latency field).
//   master modport: the initiator's view (drives req_ready, AC payload,
//                   crready, cdready, result fields, stale_cnt).
//   slave modport : the environment's view (command source, snoop responder,
//                   result sink).
interface ace_snoop_initiator_if #(
    parameter int ADDR_W = 44,
    parameter int CD_W   = 128,
    parameter int LAT_W  = 16
);
    // command port
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_snoop;
    logic [2:0]        req_prot;
    // AC channel
    logic              acvalid;
    logic              acready;
    logic [ADDR_W-1:0] acaddr;
    logic [3:0]        acsnoop;
    logic [2:0]        acprot;
    // CR channel
    logic              crvalid;
    logic              crready;
    logic [4:0]        crresp;
    // CD channel
    logic              cdvalid;
    logic              cdready;
    logic              cdlast;
    logic [CD_W-1:0]   cddata;
    // result port
    logic              rsp_valid;
    logic              rsp_ready;
    logic [4:0]        rsp_crresp;
    logic [3:0]        rsp_beats;
    logic [LAT_W-1:0]  rsp_latency;
    logic              rsp_timeout;
    logic [7:0]        stale_cnt;

    modport master (
        input  req_valid, req_addr, req_snoop, req_prot,
        output req_ready,
        output acvalid, acaddr, acsnoop, acprot,
        input  acready,
        input  crvalid, crresp,
        output crready,
        input  cdvalid, cdlast, cddata,
        output cdready,
        output rsp_valid, rsp_crresp, rsp_beats, rsp_latency, rsp_timeout,
        input  rsp_ready,
        output stale_cnt
    );

    modport slave (
        output req_valid, req_addr, req_snoop, req_prot,
        input  req_ready,
        input  acvalid, acaddr, acsnoop, acprot,
        output acready,
        output crvalid, crresp,
        input  crready,
        output cdvalid, cdlast, cddata,
        input  cdready,
        input  rsp_valid, rsp_crresp, rsp_beats, rsp_latency, rsp_timeout,
        output rsp_ready,
        input  stale_cnt
    );
endinterface

// File: rtl/ace_snoop_timer.sv
// ace_snoop_timer: CR wait timers for the snoop initiator.
//   Optional feature macro: SNOOP_LATENCY_EN (builds the latency counter;
//   otherwise latency is constant 0). The timeout counter is always built.
//   Ports:
//     clk, rst_n  clock, synchronous active-low reset
//     clear       AC handshake this cycle: restart both counters
//     run         waiting for CR this cycle
//     tmo_hit     last allowed CR cycle reached (TIMEOUT != 0 only)
//     latency     latency if the CR handshake happens this cycle
module ace_snoop_timer #(
    parameter int TIMEOUT = 1024,
    parameter int LAT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    output logic             tmo_hit,
    output logic [LAT_W-1:0] latency
);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [TMR_W-1:0] tmo_cnt;

    // Counts CR cycles already elapsed; saturates so TIMEOUT=0 never wraps
    // into a spurious match.
    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            tmo_cnt <= '0;
        else if (run && tmo_cnt != '1)
            tmo_cnt <= tmo_cnt + 1'b1;
    end

    assign tmo_hit = (TIMEOUT != 0) && run && (tmo_cnt == TMO_LAST);

`ifdef SNOOP_LATENCY_EN
    logic [LAT_W-1:0] lat_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clear)
            lat_cnt <= '0;
        else if (run && lat_cnt != '1)
            lat_cnt <= lat_cnt + 1'b1;
    end

    // A handshake in this cycle ends one edge after lat_cnt edges.
    assign latency = (lat_cnt == '1) ? lat_cnt : lat_cnt + 1'b1;
`else
    assign latency = '0;
`endif

endmodule

// File: rtl/ace_snoop_initiator.sv
// ace_snoop_initiator: interconnect-side ACE snoop initiator. Takes one
// command, issues it on AC, waits for CR (with timeout), drains CD beats
// when DataTransfer is set, and reports the outcome on the result port.
//   Optional feature macro: SNOOP_LATENCY_EN (rsp_latency reporting).
//   Parameters: TIMEOUT (CR wait limit in cycles, 0 = none), LAT_W (must
//               match the interface LAT_W). Address/data widths come from
//               the interface.
//   Ports:
//     ace_aclk     clock
//     ace_aresetn  synchronous active-low reset
//     bus          ace_snoop_initiator_if.master (req, AC, CR, CD, rsp)
module ace_snoop_initiator
    import ace_snoop_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int LAT_W   = 16
) (
    input  logic                  ace_aclk,
    input  logic                  ace_aresetn,
    ace_snoop_initiator_if.master bus
);
    snoop_state_e     state;
    logic             ac_hs;
    logic             in_cr;
    logic             tmo_hit;
    logic [LAT_W-1:0] lat_now;
    logic             unused_cddata;

    assign ac_hs = (state == ST_AC) && bus.acready;
    assign in_cr = (state == ST_CR);
    // Data beats are counted, never stored.
    assign unused_cddata = ^bus.cddata;

    ace_snoop_timer #(
        .TIMEOUT (TIMEOUT),
        .LAT_W   (LAT_W)
    ) u_timer (
        .clk     (ace_aclk),
        .rst_n   (ace_aresetn),
        .clear   (ac_hs),
        .run     (in_cr),
        .tmo_hit (tmo_hit),
        .latency (lat_now)
    );

    always_ff @(posedge ace_aclk) begin
        if (!ace_aresetn) begin
            state           <= ST_IDLE;
            bus.req_ready   <= 1'b0;
            bus.acvalid     <= 1'b0;
            bus.acaddr      <= '0;
            bus.acsnoop     <= '0;
            bus.acprot      <= '0;
            bus.crready     <= 1'b0;
            bus.cdready     <= 1'b0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_crresp  <= '0;
            bus.rsp_beats   <= '0;
            bus.rsp_latency <= '0;
            bus.rsp_timeout <= 1'b0;
            bus.stale_cnt   <= '0;
        end else begin
            // crready is also held in IDLE so a late CR for a timed-out
            // snoop is swallowed instead of stalling the responder.
            if (state == ST_IDLE && bus.crready && bus.crvalid && bus.stale_cnt != 8'hFF)
                bus.stale_cnt <= bus.stale_cnt + 8'd1;

            unique case (state)
                ST_IDLE: begin
                    bus.req_ready <= 1'b1;
                    bus.crready   <= 1'b1;
                    if (bus.req_valid && bus.req_ready) begin
                        bus.acaddr      <= bus.req_addr;
                        bus.acsnoop     <= bus.req_snoop;
                        bus.acprot      <= bus.req_prot;
                        bus.acvalid     <= 1'b1;
                        bus.req_ready   <= 1'b0;
                        bus.crready     <= 1'b0;
                        bus.rsp_crresp  <= '0;
                        bus.rsp_beats   <= '0;
                        bus.rsp_latency <= '0;
                        bus.rsp_timeout <= 1'b0;
                        state           <= ST_AC;
                    end
                end
                ST_AC: begin
                    if (bus.acready) begin
                        bus.acvalid <= 1'b0;
                        bus.crready <= 1'b1;
                        state       <= ST_CR;
                    end
                end
                ST_CR: begin
                    // A response in the timeout cycle still counts as normal.
                    if (bus.crvalid) begin
                        bus.crready     <= 1'b0;
                        bus.rsp_crresp  <= bus.crresp;
                        bus.rsp_latency <= lat_now;
                        if (bus.crresp[CR_DATA_TRANSFER]) begin
                            bus.cdready <= 1'b1;
                            state       <= ST_CD;
                        end else begin
                            bus.rsp_valid <= 1'b1;
                            state         <= ST_DONE;
                        end
                    end else if (tmo_hit) begin
                        bus.crready     <= 1'b0;
                        bus.rsp_crresp  <= '0;
                        bus.rsp_timeout <= 1'b1;
                        bus.rsp_valid   <= 1'b1;
                        state           <= ST_DONE;
                    end
                end
                ST_CD: begin
                    if (bus.cdvalid) begin
                        bus.rsp_beats <= beat_inc(bus.rsp_beats);
                        if (bus.cdlast) begin
                            bus.cdready   <= 1'b0;
                            bus.rsp_valid <= 1'b1;
                            state         <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                        bus.crready   <= 1'b1;
                        state         <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ace_snoop_initiator.sv
// tb_ace_snoop_initiator: directed bench for ace_snoop_initiator
// (TIMEOUT=16). Expected results are queued as each snoop is issued and
// a negedge monitor pops and compares them on every result handshake.
module tb_ace_snoop_initiator;
    import ace_snoop_pkg::*;

    typedef struct packed {
        logic [4:0]  crresp;
        logic [3:0]  beats;
        logic        timeout;
        logic [15:0] lat;
        logic        chk_lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    ace_snoop_initiator_if #(.ADDR_W(44), .CD_W(128), .LAT_W(16)) bus ();

    ace_snoop_initiator #(.TIMEOUT(16), .LAT_W(16)) dut (
        .ace_aclk    (clk),
        .ace_aresetn (rst_n),
        .bus         (bus.master)
    );

    function automatic void check(string name, longint unsigned act, longint unsigned exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic logic [15:0] elat(int n);
`ifdef SNOOP_LATENCY_EN
        return 16'(n);
`else
        return (n > 0) ? 16'd0 : 16'd0;
`endif
    endfunction

    function automatic logic [63:0] ctl_outs();
        return {18'd0, bus.req_ready, bus.acvalid, bus.crready, bus.cdready, bus.rsp_valid,
                bus.rsp_timeout, bus.rsp_crresp, bus.rsp_beats, bus.rsp_latency,
                bus.stale_cnt, bus.acsnoop, bus.acprot};
    endfunction

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_req(logic [43:0] a, logic [3:0] s, logic [2:0] p);
        int budget = 0;
        bit hs;
        bus.req_addr  = a;
        bus.req_snoop = s;
        bus.req_prot  = p;
        bus.req_valid = 1'b1;
        do begin
            hs = bus.req_ready;
            cyc(1);
            budget++;
        end while (!hs && budget < 50);
        bus.req_valid = 1'b0;
        check("req_accept", hs, 1);
        check("acvalid_after_req", bus.acvalid, 1);
        check("acaddr", bus.acaddr, a);
        check("ac_snoop_prot", {bus.acsnoop, bus.acprot}, {s, p});
    endtask

    task automatic ac_hs(int delay);
        logic [50:0] pl;
        pl = {bus.acaddr, bus.acsnoop, bus.acprot};
        repeat (delay) begin
            cyc(1);
            check("ac_hold", {bus.acvalid, bus.acaddr, bus.acsnoop, bus.acprot}, {1'b1, pl});
        end
        bus.acready = 1'b1;
        cyc(1);
        bus.acready = 1'b0;
        check("acvalid_drop", bus.acvalid, 0);
        check("crready_after_ac", bus.crready, 1);
    endtask

    task automatic cr_hs(int lat, logic [4:0] resp);
        repeat (lat - 1) cyc(1);
        bus.crvalid = 1'b1;
        bus.crresp  = resp;
        cyc(1);
        bus.crvalid = 1'b0;
        bus.crresp  = '0;
    endtask

    task automatic cd_beats(int n, int gap);
        for (int i = 0; i < n; i++) begin
            bus.cdvalid = 1'b1;
            bus.cdlast  = (i == n - 1);
            bus.cddata  = {$urandom, $urandom, $urandom, $urandom};
            cyc(1);
            bus.cdvalid = 1'b0;
            bus.cdlast  = 1'b0;
            if (i != n - 1) begin
                check("cd_no_early_rsp", bus.rsp_valid, 0);
                if (gap > 0) cyc(gap);
            end
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_rsp", bus.rsp_valid, 0);
            end else begin
                e = sb.pop_front();
                check("rsp_crresp", bus.rsp_crresp, e.crresp);
                check("rsp_beats", bus.rsp_beats, e.beats);
                check("rsp_timeout", bus.rsp_timeout, e.timeout);
                if (e.chk_lat) check("rsp_latency", bus.rsp_latency, e.lat);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no_finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req_valid = 0; bus.req_addr = '0; bus.req_snoop = '0; bus.req_prot = '0;
        bus.acready = 0; bus.crvalid = 0; bus.crresp = '0;
        bus.cdvalid = 0; bus.cdlast = 0; bus.cddata = '0; bus.rsp_ready = 0;
        cyc(3);
        check("reset_outputs", ctl_outs(), 0);
        check("reset_acaddr", bus.acaddr, 0);
        rst_n = 1'b1;
        cyc(1);
        check("req_ready_post_reset", bus.req_ready, 1);
        check("crready_idle", bus.crready, 1);

        // T1: ReadShared, non-data response two cycles after AC, result backpressured
        sb.push_back('{5'b00000, 4'd0, 1'b0, elat(2), 1'b1});
        send_req(44'h10, SNP_READ_SHARED, 3'b010);
        ac_hs(0);
        cr_hs(2, 5'b00000);
        check("t1_rsp_valid", bus.rsp_valid, 1);
        check("t1_cdready", bus.cdready, 0);
        cyc(3);
        check("t1_rsp_hold", {bus.rsp_valid, bus.rsp_crresp, bus.rsp_beats}, {1'b1, 5'd0, 4'd0});
        bus.rsp_ready = 1'b1;
        cyc(1);
        check("t1_req_ready_next", bus.req_ready, 1);
        check("t1_rsp_drop", bus.rsp_valid, 0);

        // T2: ReadUnique with data, four beats with idle gaps
        sb.push_back('{5'b00101, 4'd4, 1'b0, elat(3), 1'b1});
        send_req(44'h123_4567_89C0, SNP_READ_UNIQUE, 3'b000);
        ac_hs(1);
        cr_hs(3, 5'b00101);
        check("t2_cdready", bus.cdready, 1);
        check("t2_no_rsp_yet", bus.rsp_valid, 0);
        cd_beats(4, 1);
        check("t2_rsp_after_last", bus.rsp_valid, 1);
        cyc(1);

        // T3: no response -> timeout at 16 cycles, then a stale CR in IDLE
        sb.push_back('{5'b00000, 4'd0, 1'b1, 16'd0, 1'b0});
        send_req(44'hF_0000_0040, SNP_CLEAN_SHARED, 3'b001);
        ac_hs(0);
        cyc(15);
        check("t3_no_early_timeout", bus.rsp_valid, 0);
        cyc(1);
        check("t3_timeout_valid", {bus.rsp_valid, bus.rsp_timeout}, 2'b11);
        cyc(1);
        check("t3_crready_idle", bus.crready, 1);
        cyc(2);
        bus.crvalid = 1'b1;
        bus.crresp  = 5'b00001;
        cyc(1);
        bus.crvalid = 1'b0;
        bus.crresp  = '0;
        check("t3_stale_cnt", bus.stale_cnt, 1);
        cyc(3);

        // T4: acready delayed five cycles; latency counted from the handshake
        sb.push_back('{5'b01000, 4'd0, 1'b0, elat(3), 1'b1});
        send_req(44'hABC_DEF0_1200, SNP_READ_CLEAN, 3'b101);
        ac_hs(5);
        cr_hs(3, 5'b01000);
        check("t4_rsp_valid", bus.rsp_valid, 1);
        cyc(1);

        // T5: reset while waiting for CR, then a normal data snoop
        send_req(44'h0_0000_0100, SNP_READ_ONCE, 3'b011);
        ac_hs(0);
        cyc(2);
        rst_n = 1'b0;
        cyc(1);
        check("t5_reset_outputs", ctl_outs(), 0);
        check("t5_reset_acaddr", bus.acaddr, 0);
        rst_n = 1'b1;
        sb.push_back('{5'b10001, 4'd2, 1'b0, elat(1), 1'b1});
        send_req(44'h0_0000_0200, SNP_READ_NSD, 3'b000);
        ac_hs(2);
        cr_hs(1, 5'b10001);
        cd_beats(2, 0);
        check("t5_rsp_valid", bus.rsp_valid, 1);
        cyc(1);

        // T6: crvalid exactly in the timeout cycle is a normal response
        sb.push_back('{5'b00010, 4'd0, 1'b0, elat(16), 1'b1});
        send_req(44'h0_0000_0300, SNP_CLEAN_INVALID, 3'b000);
        ac_hs(0);
        cr_hs(16, 5'b00010);
        check("t6_rsp_normal", {bus.rsp_valid, bus.rsp_timeout}, 2'b10);
        cyc(1);

        // T7: beat count saturates at 15
        sb.push_back('{5'b00001, 4'd15, 1'b0, elat(1), 1'b1});
        send_req(44'h0_0000_0400, SNP_READ_ONCE, 3'b000);
        ac_hs(0);
        cr_hs(1, 5'b00001);
        cd_beats(17, 0);
        check("t7_rsp_valid", bus.rsp_valid, 1);
        cyc(3);

        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
